// File: rtl/ad7324_spi_responder.sv
// Stand-in for the AD7324 on the ADC SPI link: returns per-channel test frames on DOUT
// and captures master writes from DIN. Everything runs on CLK20M with oversampled pins.
module ad7324_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 13
) (
  input  logic                 CLK20M,
  input  logic                 RSTp,
  input  logic                 CS,
  input  logic                 SCLK,
  input  logic                 DIN,
  input  logic [DATA_BITS-1:0] CH0_DATA,
  input  logic [DATA_BITS-1:0] CH1_DATA,
  input  logic [DATA_BITS-1:0] CH2_DATA,
  input  logic [DATA_BITS-1:0] CH3_DATA,
  output logic                 DOUT,
  output logic                 DOUT_OE,
  output logic [1:0]           CH_CUR,
  output logic [15:0]          CTRL_WORD,
  output logic                 CTRL_VALID,
  output logic                 FRAME_ERR
);

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Pin synchronizers; deliberately not reset so a CS held low through reset
  // never looks like a fresh falling edge afterwards.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], DIN};
  end

  always_ff @(posedge CLK20M) begin
    cs_sync_q   <= cs_sync_d;
    sclk_sync_q <= sclk_sync_d;
    din_sync_q  <= din_sync_d;
  end

  logic cs_s, sclk_s, din_s;
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  state_e      state_q, state_d;
  logic        cs_prev_q, cs_prev_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  ch_q, ch_d;
  logic [15:0] ctrl_word_q, ctrl_word_d;
  logic        ctrl_valid_q, ctrl_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        dout_q, dout_d;
  logic        oe_q, oe_d;

  // cs_prev resets low: a fall needs a high level observed after reset first.
  logic cs_fall, cs_rise, sclk_fall;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  logic [DATA_BITS-1:0] sel_data;
  logic [15:0]          tx_load;

  always_comb begin
    sel_data = CH0_DATA;
    case (ch_q)
      2'd0: sel_data = CH0_DATA;
      2'd1: sel_data = CH1_DATA;
      2'd2: sel_data = CH2_DATA;
      2'd3: sel_data = CH3_DATA;
      default: sel_data = CH0_DATA;
    endcase
    tx_load = {1'b0, ch_q, 13'(sel_data)};
  end

  always_comb begin
    state_d      = state_q;
    cs_prev_d    = cs_s;
    sclk_prev_d  = sclk_s;
    tx_d         = tx_q;
    rx_d         = rx_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    dout_d       = dout_q;
    oe_d         = oe_q;

    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        oe_d   = 1'b0;
        cnt_d  = 5'd0;
        if (cs_fall) begin
          tx_d    = tx_load;
          rx_d    = 16'd0;
          dout_d  = tx_load[15];
          oe_d    = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        oe_d = 1'b1;
        // CS rise takes priority over a coincident SCLK fall.
        if (cs_rise) begin
          oe_d    = 1'b0;
          dout_d  = 1'b0;
          state_d = DONE;
        end else if (sclk_fall) begin
          rx_d   = {rx_q[14:0], din_s};
          tx_d   = {tx_q[14:0], 1'b0};
          dout_d = tx_q[14];
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end

      DONE: begin
        oe_d    = 1'b0;
        dout_d  = 1'b0;
        state_d = IDLE;
        if (cnt_q == CNT_FULL) begin
          if (rx_q[15]) begin
            ctrl_word_d  = rx_q;
            ctrl_valid_d = 1'b1;
            // Register address 00 is the control register: it carries the channel pointer.
            if (rx_q[14:13] == 2'b00) ch_d = rx_q[11:10];
            else                      ch_d = ch_q + 2'd1;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK20M) begin
    if (RSTp) begin
      state_q      <= IDLE;
      cs_prev_q    <= 1'b0;
      sclk_prev_q  <= 1'b1;
      tx_q         <= 16'd0;
      rx_q         <= 16'd0;
      cnt_q        <= 5'd0;
      ch_q         <= 2'd0;
      ctrl_word_q  <= 16'd0;
      ctrl_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dout_q       <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_prev_q    <= cs_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      frame_err_q  <= frame_err_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_OE    = oe_q;
  assign CH_CUR     = ch_q;
  assign CTRL_WORD  = ctrl_word_q;
  assign CTRL_VALID = ctrl_valid_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_ad7324_spi_responder.sv
// Directed plus randomized frames against a frame-level reference model of the responder.
module tb_ad7324_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, sclk, din;
  logic [12:0] ch0, ch1, ch2, ch3;
  logic        dout, dout_oe, ctrl_valid, frame_err;
  logic [1:0]  ch_cur;
  logic [15:0] ctrl_word;

  int checks = 0;
  int failures = 0;

  int          mdl_ch;
  logic [15:0] mdl_ctrl;

  always #25 clk = ~clk;

  ad7324_spi_responder #(.SYNC_STAGES(2), .DATA_BITS(13)) dut (
    .CLK20M(clk), .RSTp(rst), .CS(cs), .SCLK(sclk), .DIN(din),
    .CH0_DATA(ch0), .CH1_DATA(ch1), .CH2_DATA(ch2), .CH3_DATA(ch3),
    .DOUT(dout), .DOUT_OE(dout_oe), .CH_CUR(ch_cur),
    .CTRL_WORD(ctrl_word), .CTRL_VALID(ctrl_valid), .FRAME_ERR(frame_err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ch_value(input int c);
    case (c)
      0: return ch0;
      1: return ch1;
      2: return ch2;
      default: return ch3;
    endcase
  endfunction

  // One frame with nf SCLK falls, DIN word din_w, optional CH1 change after the CS fall.
  task automatic run_frame(input int nf, input logic [15:0] din_w,
                           input bit mod, input logic [12:0] mod_val);
    logic [15:0] exp_w, got_w;
    int          old_ch, new_ch;
    bit          good, exp_v, exp_e;
    exp_w  = 16'((mdl_ch << 13) + int'(ch_value(mdl_ch)));
    got_w  = 16'd0;
    old_ch = mdl_ch;
    cs = 1'b0;
    tick(4);
    chk("oe_on", {31'd0, dout_oe}, 32'd1);
    if (mod) ch1 = mod_val;
    for (int i = 0; i < nf; i++) begin
      if (i < 16) got_w[15-i] = dout;
      sclk = 1'b0;
      din  = (i < 16) ? din_w[15-i] : 1'b0;
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    if (nf >= 16) chk("dout_tail", {31'd0, dout}, 32'd0);
    if (nf >= 16) chk("dout_word", {16'd0, got_w}, {16'd0, exp_w});
    else chk("dout_prefix", 32'(got_w >> (16 - nf)), 32'(exp_w >> (16 - nf)));

    good  = (nf == 16);
    exp_v = good && din_w[15];
    exp_e = !good;
    new_ch = old_ch;
    if (good) begin
      if (din_w[15] && din_w[14:13] == 2'b00) new_ch = int'(din_w[11:10]);
      else new_ch = (old_ch + 1) % 4;
      if (din_w[15]) mdl_ctrl = din_w;
    end

    cs  = 1'b1;
    din = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      tick(1);
      chk("ctrl_valid_t", {31'd0, ctrl_valid}, {31'd0, (s == 4) && exp_v});
      chk("frame_err_t", {31'd0, frame_err}, {31'd0, (s == 4) && exp_e});
      if (s == 2) chk("oe_hold", {31'd0, dout_oe}, 32'd1);
      if (s == 3) chk("oe_off", {31'd0, dout_oe}, 32'd0);
      if (s == 3) chk("ch_before", {30'd0, ch_cur}, 32'(old_ch));
      if (s >= 4) chk("ch_after", {30'd0, ch_cur}, 32'(new_ch));
    end
    mdl_ch = new_ch;
    chk("ctrl_word", {16'd0, ctrl_word}, {16'd0, mdl_ctrl});
    tick(2);
  endtask

  initial begin
    logic [15:0] w;
    int          nf;
    rst = 1'b1; cs = 1'b1; sclk = 1'b1; din = 1'b0;
    ch0 = 13'h0123; ch1 = 13'h1F00; ch2 = 13'h0FFF; ch3 = 13'h1000;
    mdl_ch = 0; mdl_ctrl = 16'd0;
    tick(5);
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_oe", {31'd0, dout_oe}, 32'd0);
    chk("rst_ch", {30'd0, ch_cur}, 32'd0);
    chk("rst_ctrl", {16'd0, ctrl_word}, 32'd0);
    chk("rst_pulses", {30'd0, ctrl_valid, frame_err}, 32'd0);
    rst = 1'b0;
    tick(6);

    // Four read frames walk the channels: 0x0123, 0x3F00, 0x4FFF, 0x7000.
    for (int k = 0; k < 4; k++) run_frame(16, 16'h0000, 1'b0, 13'd0);
    chk("ch_wrap", {30'd0, ch_cur}, 32'd0);

    run_frame(16, 16'h8C00, 1'b0, 13'd0);
    chk("ctrl_8c00", {16'd0, ctrl_word}, 32'h8C00);
    chk("ch_set3", {30'd0, ch_cur}, 32'd3);

    run_frame(15, 16'h0000, 1'b0, 13'd0);
    run_frame(17, 16'hFFFF, 1'b0, 13'd0);
    chk("ch_after_err", {30'd0, ch_cur}, 32'd3);

    // Point at channel 1, then change its data mid-frame.
    ch1 = 13'h0055;
    run_frame(16, 16'h8400, 1'b0, 13'd0);
    chk("ch_set1", {30'd0, ch_cur}, 32'd1);
    run_frame(16, 16'h0000, 1'b1, 13'h00AA);
    run_frame(16, 16'h8400, 1'b0, 13'd0);
    run_frame(16, 16'h0000, 1'b0, 13'd0);

    // Reset in the middle of a frame with CS held low.
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; din = 1'b1; tick(4); sclk = 1'b1; tick(4);
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; tick(4);
      chk("rst_mid_dout", {31'd0, dout}, 32'd0);
      sclk = 1'b1; tick(4);
    end
    cs = 1'b1; din = 1'b0;
    for (int s = 0; s < 6; s++) begin
      tick(1);
      chk("rst_mid_pulses", {30'd0, ctrl_valid, frame_err}, 32'd0);
    end
    chk("rst_mid_ch", {30'd0, ch_cur}, 32'd0);
    chk("rst_mid_oe", {31'd0, dout_oe}, 32'd0);
    mdl_ch = 0; mdl_ctrl = 16'd0;
    tick(4);
    run_frame(16, 16'h0000, 1'b0, 13'd0);

    // Stray SCLK edges while deselected.
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0; din = 1'b1; tick(4); sclk = 1'b1; tick(4);
    end
    din = 1'b0;
    tick(2);
    run_frame(16, 16'h0000, 1'b0, 13'd0);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      ch0 = 13'($urandom); ch1 = 13'($urandom);
      ch2 = 13'($urandom); ch3 = 13'($urandom);
      case ($urandom_range(0, 2))
        0: w = {1'b0, 15'($urandom)};
        1: w = {1'b1, 2'b00, 1'b0, 2'($urandom), 10'($urandom)};
        default: w = {1'b1, 2'($urandom_range(1, 3)), 13'($urandom)};
      endcase
      nf = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
      run_frame(nf, w, 1'b0, 13'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
